// File: rtl/fuzz_response_checker_pkg.sv
// Shared constants and FSM state type for the fuzz response checker.
package fuzz_pkg;
  localparam int FUZZ_Y_W = 82;
  localparam int FUZZ_NUM_SAMPLES = 21;
  localparam logic [FUZZ_Y_W-1:0] FUZZ_POLY = 82'h0_0000_0000_0000_0000_0041;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fuzz_state_e;
endpackage

// File: rtl/fuzz_response_checker_if.sv
// Sampled result stream: reference and implementation-under-test words with a shared valid.
interface fuzz_response_checker_if #(
  parameter int W = fuzz_pkg::FUZZ_Y_W
) ();
  logic         sample_valid;
  logic [W-1:0] y_ref;
  logic [W-1:0] y_dut;

  modport master (output sample_valid, output y_ref, output y_dut);
  modport slave  (input  sample_valid, input  y_ref, input  y_dut);
endinterface

// File: rtl/fuzz_response_checker_misr.sv
// Multiple-input signature register folding one data word per enabled cycle.
module fuzz_misr #(
  parameter int WIDTH = 82,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : {WIDTH{1'b0}}) ^ d;
    end
  end
endmodule

// File: rtl/fuzz_response_checker.sv
// Compares reference vs. synthesised result streams and produces a pass/fail verdict.
// Define FUZZ_CHECKER_MISR_EN to build the signature register over y_dut.
module fuzz_response_checker
  import fuzz_pkg::*;
#(
  parameter int WIDTH = FUZZ_Y_W,
  parameter int CNT_W = 16,
  parameter int NUM_SAMPLES = FUZZ_NUM_SAMPLES,
  parameter logic [WIDTH-1:0] POLY = FUZZ_POLY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  fuzz_response_checker_if.slave    smp,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [CNT_W-1:0]          mismatch_cnt,
  output logic [CNT_W-1:0]          first_idx,
  output logic [WIDTH-1:0]          first_diff,
  output logic [WIDTH-1:0]          signature
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fuzz_state_e      state_q;
  logic             seen_q;
  logic             done_q;
  logic             start_acc;
  logic             accept;
  logic             last;
  logic             end_run;
  logic [WIDTH-1:0] diff;

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign accept    = (state_q == RUN) && smp.sample_valid;
  assign last      = accept && (sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign end_run   = (state_q == RUN) && (stop || last);
  assign diff      = smp.y_ref ^ smp.y_dut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seen_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      first_idx    <= '0;
      first_diff   <= '0;
    end else begin
      done_q <= end_run;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            seen_q       <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_diff   <= '0;
          end
        end
        RUN: begin
          // A sample arriving with stop is still counted before the run closes.
          if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (diff != '0) begin
              mismatch_cnt <= sat_inc(mismatch_cnt);
              if (!seen_q) begin
                seen_q     <= 1'b1;
                first_idx  <= sample_cnt;
                first_diff <= diff;
              end
            end
          end
          if (end_run) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign pass = (state_q == DONE) && (mismatch_cnt == '0);

`ifdef FUZZ_CHECKER_MISR_EN
  fuzz_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (accept),
    .d   (smp.y_dut),
    .sig (signature)
  );
`else
  logic unused_misr;
  assign unused_misr = start_acc ^ (^POLY);
  assign signature   = '0;
`endif
endmodule
